// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the programmable clock divider.
//   ch_state_t  : per-channel FSM state (IDLE / RUN / STOP)
//   MIN_DIV     : smallest period a channel can run at
//   SAN_W       : working width of the sanitise helper (CNT_WIDTH must be <= SAN_W)
//   cfg_pair_t  : sanitised {period, high time} pair
//   sanitise()  : clamps a requested period/high-time pair into a legal one
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ch_state_t;

    localparam int MIN_DIV = 2;
    localparam int SAN_W   = 32;

    typedef struct packed {
        logic [SAN_W-1:0] p;
        logic [SAN_W-1:0] h;
    } cfg_pair_t;

    // Period is at least MIN_DIV; high time is at least 1 and leaves at
    // least one low cycle, so every period has exactly one rising edge.
    function automatic cfg_pair_t sanitise(input logic [SAN_W-1:0] div,
                                           input logic [SAN_W-1:0] high);
        cfg_pair_t r;
        r.p = (div < SAN_W'(MIN_DIV)) ? SAN_W'(MIN_DIV) : div;
        r.h = (high == '0) ? SAN_W'(1) : high;
        if (r.h > r.p - SAN_W'(1)) begin
            r.h = r.p - SAN_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// ---------------------------------------------------------------------------
// clk_div_ch
// One divider channel: en synchroniser, IDLE/RUN/STOP FSM, period counter,
// active and pending configuration registers.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   en               : asynchronous enable (synchronised here)
//   div_cfg/high_cfg : requested period / high time
//   cfg_load         : capture div_cfg/high_cfg into the pending register
//   align            : restart a running channel at cnt=0
//   clk_out, tick    : registered divided clock, rising-edge strobe
//   cfg_pend         : a captured configuration awaits a period boundary
//   state            : current FSM state (debug / running indication)
// Handshake: none; cfg_load and align are single-cycle synchronous strobes
// sampled on the rising edge of clk, with no back-pressure.
// ---------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int RST_DIV   = 20,
    parameter int RST_HIGH  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_cfg,
    input  logic [CNT_WIDTH-1:0] high_cfg,
    input  logic                 cfg_load,
    input  logic                 align,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 cfg_pend,
    output ch_state_t            state
);

    logic                 en_meta;
    logic                 en_s;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] act_p;
    logic [CNT_WIDTH-1:0] act_h;
    logic [CNT_WIDTH-1:0] pend_p;
    logic [CNT_WIDTH-1:0] pend_h;

    ch_state_t            state_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 clk_n;
    logic                 tick_n;
    logic                 apply;
    logic                 wrap;

    cfg_pair_t            san;
    logic                 unused_san;

    // Inputs are zero-extended, so the bits above CNT_WIDTH are always zero.
    assign san        = sanitise(SAN_W'(div_cfg), SAN_W'(high_cfg));
    assign unused_san = ^san;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clk_n   = 1'b0;
        tick_n  = 1'b0;
        apply   = 1'b0;
        cnt_inc = cnt + CNT_WIDTH'(1);
        wrap    = (cnt == act_p - CNT_WIDTH'(1));

        unique case (state)
            IDLE: begin
                // Nothing is running, so a pending config can land at once.
                cnt_n = '0;
                apply = cfg_pend;
                if (en_s) begin
                    state_n = RUN;
                    clk_n   = 1'b1;
                    tick_n  = 1'b1;
                end
            end
            RUN, STOP: begin
                if (wrap && !en_s) begin
                    // Period completed with enable gone: park low. An align
                    // on this same edge merges into this wrap.
                    state_n = IDLE;
                    cnt_n   = '0;
                    apply   = cfg_pend;
                end else if (wrap || align) begin
                    // Period boundary (natural or forced): one restart, one tick.
                    state_n = en_s ? RUN : STOP;
                    cnt_n   = '0;
                    clk_n   = 1'b1;
                    tick_n  = 1'b1;
                    apply   = cfg_pend;
                end else begin
                    state_n = en_s ? RUN : STOP;
                    cnt_n   = cnt_inc;
                    clk_n   = (cnt_inc < act_h);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_meta  <= 1'b0;
            en_s     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            act_p    <= CNT_WIDTH'(RST_DIV);
            act_h    <= CNT_WIDTH'(RST_HIGH);
            pend_p   <= CNT_WIDTH'(RST_DIV);
            pend_h   <= CNT_WIDTH'(RST_HIGH);
            cfg_pend <= 1'b0;
        end else begin
            en_meta <= en;
            en_s    <= en_meta;
            state   <= state_n;
            cnt     <= cnt_n;
            clk_out <= clk_n;
            tick    <= tick_n;
            // apply uses the value pending before this edge, so a cfg_load
            // on a boundary edge waits for the following boundary.
            if (apply) begin
                act_p <= pend_p;
                act_h <= pend_h;
            end
            if (cfg_load) begin
                pend_p <= san.p[CNT_WIDTH-1:0];
                pend_h <= san.h[CNT_WIDTH-1:0];
            end
            cfg_pend <= cfg_load | (cfg_pend & ~apply);
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// Multi-channel runtime-programmable glitch-free clock divider.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : per-channel enable (asynchronous)
//   div_cfg    : per-channel period, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   high_cfg   : per-channel high time, same packing
//   cfg_load   : per-channel capture strobe for div_cfg/high_cfg
//   align      : restart every running channel at cnt=0
//   clk_out    : divided clocks (registered)
//   tick       : one-cycle strobe with each clk_out rising edge
//   cfg_pend   : configuration captured but not yet applied
//   running    : channel is in RUN or STOP
// ---------------------------------------------------------------------------
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16,
    parameter int RST_DIV   = 20,
    parameter int RST_HIGH  = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           en,
    input  logic [NUM_CH*CNT_WIDTH-1:0] div_cfg,
    input  logic [NUM_CH*CNT_WIDTH-1:0] high_cfg,
    input  logic [NUM_CH-1:0]           cfg_load,
    input  logic                        align,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           cfg_pend,
    output logic [NUM_CH-1:0]           running
);

    ch_state_t ch_state [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_WIDTH (CNT_WIDTH),
            .RST_DIV   (RST_DIV),
            .RST_HIGH  (RST_HIGH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[i]),
            .div_cfg  (div_cfg[i*CNT_WIDTH +: CNT_WIDTH]),
            .high_cfg (high_cfg[i*CNT_WIDTH +: CNT_WIDTH]),
            .cfg_load (cfg_load[i]),
            .align    (align),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .cfg_pend (cfg_pend[i]),
            .state    (ch_state[i])
        );

        assign running[i] = (ch_state[i] != IDLE);
    end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    localparam int NUM_CH = 2;
    localparam int CW     = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH*CW-1:0] div_cfg;
    logic [NUM_CH*CW-1:0] high_cfg;
    logic [NUM_CH-1:0]    cfg_load;
    logic                 align;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    cfg_pend;
    logic [NUM_CH-1:0]    running;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    bit model_on = 0;

    // Reference model: each running channel is described by the edge on which
    // its current period began plus the active and pending (period, high).
    int m_start [NUM_CH];
    int m_p     [NUM_CH];
    int m_h     [NUM_CH];
    int m_pp    [NUM_CH];
    int m_ph    [NUM_CH];
    bit m_pend  [NUM_CH];

    clk_div_prog #(
        .NUM_CH    (NUM_CH),
        .CNT_WIDTH (CW),
        .RST_DIV   (20),
        .RST_HIGH  (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_cfg  (div_cfg),
        .high_cfg (high_cfg),
        .cfg_load (cfg_load),
        .align    (align),
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_pend (cfg_pend),
        .running  (running)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clamp(input int d, input int h, output int p, output int hh);
        p  = (d < 2) ? 2 : d;
        hh = (h < 1) ? 1 : h;
        if (hh > p - 1) hh = p - 1;
    endtask

    task automatic model_edge();
        int ph;
        for (int c = 0; c < NUM_CH; c++) begin
            ph = edge_n - m_start[c];
            if (align || ph == m_p[c]) begin
                m_start[c] = edge_n;
                if (m_pend[c]) begin
                    m_p[c]    = m_pp[c];
                    m_h[c]    = m_ph[c];
                    m_pend[c] = 0;
                end
            end
            if (cfg_load[c]) begin
                clamp(int'(div_cfg[c*CW +: CW]), int'(high_cfg[c*CW +: CW]), m_pp[c], m_ph[c]);
                m_pend[c] = 1;
            end
            chk($sformatf("rnd clk_out ch%0d", c), clk_out[c], (edge_n - m_start[c]) < m_h[c]);
            chk($sformatf("rnd tick ch%0d", c), tick[c], edge_n == m_start[c]);
            chk($sformatf("rnd cfg_pend ch%0d", c), cfg_pend[c], m_pend[c]);
            chk($sformatf("rnd running ch%0d", c), running[c], 1);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (model_on) model_edge();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int c, input int d, input int h);
        div_cfg[c*CW +: CW]  = CW'(d);
        high_cfg[c*CW +: CW] = CW'(h);
        cfg_load[c] = 1'b1;
        step();
        cfg_load = '0;
    endtask

    task automatic wait_tick(input int c, input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick[c] !== 1'b1 && n < limit);
        chk($sformatf("wait_tick ch%0d", c), tick[c], 1);
    endtask

    initial begin
        int d;
        int h;
        rst_n    = 1'b0;
        en       = '0;
        div_cfg  = '0;
        high_cfg = '0;
        cfg_load = '0;
        align    = 1'b0;

        // reset state
        #12;
        chk("rst clk_out", clk_out, 0);
        chk("rst tick", tick, 0);
        chk("rst cfg_pend", cfg_pend, 0);
        chk("rst running", running, 0);
        #5 rst_n = 1'b1;
        step();
        chk("post-rst clk_out", clk_out, 0);

        // defaults 20/10 on ch0, three-edge start latency
        en[0] = 1'b1;
        steps(2);
        chk("t1 pre-start", clk_out[0], 0);
        step();
        chk("t1 first high", clk_out[0], 1);
        chk("t1 first tick", tick[0], 1);
        chk("t1 running", running[0], 1);
        for (int k = 1; k < 40; k++) begin
            step();
            chk("t1 clk_out", clk_out[0], (k % 20) < 10);
            chk("t1 tick", tick[0], (k % 20) == 0);
        end

        // odd ratio 7/3 on ch1, loaded while idle
        load(1, 7, 3);
        chk("t2 pend set", cfg_pend[1], 1);
        step();
        chk("t2 pend cleared idle", cfg_pend[1], 0);
        en[1] = 1'b1;
        steps(2);
        chk("t2 pre-start", clk_out[1], 0);
        step();
        chk("t2 first high", clk_out[1], 1);
        chk("t2 first tick", tick[1], 1);
        for (int k = 1; k < 14; k++) begin
            step();
            chk("t2 clk_out", clk_out[1], (k % 7) < 3);
            chk("t2 tick", tick[1], (k % 7) == 0);
        end

        // mid-period reprogram of ch0 to 8/2 at cnt=5
        wait_tick(0, 25);
        for (int k = 1; k < 20; k++) begin
            if (k == 5) begin
                div_cfg[0 +: CW]  = CW'(8);
                high_cfg[0 +: CW] = CW'(2);
                cfg_load[0] = 1'b1;
            end
            step();
            cfg_load = '0;
            chk("t3 old period", clk_out[0], k < 10);
            if (k >= 5) chk("t3 pend held", cfg_pend[0], 1);
        end
        for (int k = 0; k < 24; k++) begin
            step();
            chk("t3 new clk_out", clk_out[0], (k % 8) < 2);
            chk("t3 new tick", tick[0], (k % 8) == 0);
            chk("t3 pend clear", cfg_pend[0], 0);
        end

        // clamping on ch1
        load(1, 0, 0);
        wait_tick(1, 10);
        chk("t4a pend clear", cfg_pend[1], 0);
        for (int k = 1; k < 6; k++) begin
            step();
            chk("t4a clk_out P2H1", clk_out[1], (k % 2) == 0);
        end
        load(1, 5, 9);
        wait_tick(1, 10);
        for (int k = 1; k < 10; k++) begin
            step();
            chk("t4b clk_out P5H4", clk_out[1], (k % 5) < 4);
        end

        // graceful stop on ch0 at 20/10
        load(0, 20, 10);
        wait_tick(0, 12);
        steps(2);
        en[0] = 1'b0;
        for (int k = 3; k < 20; k++) begin
            step();
            chk("t5 stop clk_out", clk_out[0], k < 10);
            chk("t5 stop running", running[0], 1);
        end
        step();
        chk("t5 idle clk_out", clk_out[0], 0);
        chk("t5 idle running", running[0], 0);
        chk("t5 idle tick", tick[0], 0);
        steps(3);
        chk("t5 idle stays low", clk_out[0], 0);
        en[0] = 1'b1;
        steps(3);
        chk("t5 restart high", clk_out[0], 1);
        for (int k = 1; k < 40; k++) begin
            if (k == 3) en[0] = 1'b0;
            if (k == 8) en[0] = 1'b1;
            step();
            chk("t5 resume clk_out", clk_out[0], (k % 20) < 10);
            chk("t5 resume tick", tick[0], (k % 20) == 0);
            chk("t5 resume running", running[0], 1);
        end

        // align of 10/5 and 5/4, then async reset mid-high
        load(0, 10, 5);
        wait_tick(0, 25);
        steps(3);
        align = 1'b1;
        step();
        align = 1'b0;
        chk("t6 align clk_out", clk_out, 2'b11);
        chk("t6 align tick", tick, 2'b11);
        steps(2);
        chk("t6 both high", clk_out, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async rst clk_out", clk_out, 0);
        chk("t6 async rst tick", tick, 0);
        chk("t6 async rst running", running, 0);
        chk("t6 async rst cfg_pend", cfg_pend, 0);
        #3 rst_n = 1'b1;
        steps(2);
        chk("t6 post-rst low", clk_out, 2'b00);
        step();
        chk("t6 post-rst start", clk_out, 2'b11);
        chk("t6 post-rst tick", tick, 2'b11);
        for (int k = 1; k < 20; k++) begin
            step();
            chk("t6 defaults restored", clk_out, ((k % 20) < 10) ? 2'b11 : 2'b00);
        end

        // randomized run against the reference model
        en = '0;
        steps(30);
        chk("rnd pre idle", running, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            d = $urandom_range(0, 12);
            h = $urandom_range(0, 14);
            div_cfg[c*CW +: CW]  = CW'(d);
            high_cfg[c*CW +: CW] = CW'(h);
            clamp(d, h, m_p[c], m_h[c]);
            m_pend[c] = 0;
        end
        cfg_load = '1;
        step();
        cfg_load = '0;
        step();
        chk("rnd idle apply", cfg_pend, 0);
        en = '1;
        steps(3);
        for (int c = 0; c < NUM_CH; c++) m_start[c] = edge_n;
        chk("rnd start clk_out", clk_out, 2'b11);
        chk("rnd start tick", tick, 2'b11);
        model_on = 1;
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_cfg[c*CW +: CW]  = CW'($urandom_range(0, 12));
                high_cfg[c*CW +: CW] = CW'($urandom_range(0, 14));
                cfg_load[c] = ($urandom_range(0, 15) == 0);
            end
            align = ($urandom_range(0, 39) == 0);
            step();
            cfg_load = '0;
            align    = 1'b0;
        end
        model_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Multi-channel, runtime-programmable clock divider for sensor/camera reference clocks and slow peripheral strobes. Each channel has an independent period, high time and enable. Configuration changes and enable/disable take effect only at period boundaries, so outputs never glitch. Channels can be phase-aligned with a single pulse.

Parameters:
NUM_CH, 2, number of independent output channels (1..8)
CNT_WIDTH, 16, width of period/high-time fields and internal counters
RST_DIV, 20, period (in clk cycles) loaded into every channel at reset
RST_HIGH, 10, high time loaded into every channel at reset

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel enable; asynchronous, synchronised internally
div_cfg  input  NUM_CH*CNT_WIDTH  requested period per channel, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
high_cfg  input  NUM_CH*CNT_WIDTH  requested high time per channel, same packing
cfg_load  input  NUM_CH  one-cycle strobe: capture that channel's div_cfg/high_cfg into its pending register
align  input  1  one-cycle strobe: restart all running channels at cnt=0
clk_out  output  NUM_CH  divided clock outputs, registered
tick  output  NUM_CH  one-cycle strobe coincident with each rising edge of clk_out
cfg_pend  output  NUM_CH  high while a captured configuration is waiting for a boundary
running  output  NUM_CH  high while the channel is in RUN or STOP

Behaviour:
- Reset (rst_n low, async): clk_out=0, tick=0, cfg_pend=0, running=0, cnt=0, state IDLE, active period P=RST_DIV, active high H=RST_HIGH, synchronisers cleared.
- en passes through a 2-flop synchroniser per bit (en_s). align and cfg_load are synchronous; they are not synchronised.
- Sanitise at capture: P = max(div_cfg, 2); H = min(max(high_cfg, 1), P-1). The sanitised values are stored; raw values are never used.
- Counter: cnt runs 0..P-1 and wraps. clk_out is registered, with clk_out=1 for cnt in [0, H-1] and 0 otherwise. The output period is exactly P cycles with H cycles high. Odd P is supported.
- Per-channel FSM:
  - IDLE: cnt=0, clk_out=0. When en_s=1, go to RUN on the next edge with cnt=0, clk_out=1, tick=1. Latency from en rising to first clk_out high is 3 clk edges.
  - RUN: count. At cnt=P-1, apply the pending config if any, then wrap to 0 with tick=1. If en_s=0 is seen, go to STOP.
  - STOP: keep counting until cnt=P-1 completes the current period, then go to IDLE. clk_out ends low, and no truncated high pulse is ever produced. If en_s returns to 1 while in STOP, go back to RUN with no disruption.
- Config update:
  - A cfg_load capture sets cfg_pend.
  - In IDLE or STOP-exit, the pending config applies immediately, i.e. before the next start.
  - In RUN, it applies at the wrap edge, and cfg_pend clears on that same edge.
  - A second cfg_load before application overwrites the pending value; last write wins.
- align: every channel in RUN or STOP restarts on the next edge at cnt=0, clk_out=1, tick=1. A pending config applies at that point. IDLE channels ignore align.
- Same-cycle events:
  - align together with the natural wrap behaves as a single wrap, with one tick.
  - cfg_load in the same cycle as the wrap is not applied at that wrap; it waits for the next boundary.
- tick equals rising clk_out, registered in the same cycle as the clk_out 0->1 transition. tick is never asserted in IDLE.
- Channels are fully independent except for the shared align input.

Decomposition:
- Package clk_div_pkg holds:
  - ch_state_t enum {IDLE, RUN, STOP}
  - localparam MIN_DIV=2
  - a sanitise function taking (div, high) and returning the clamped pair
- Sub-module clk_div_ch holds one channel: FSM, counter, active and pending registers, and the en synchroniser. The top level generate-loops NUM_CH instances and slices the packed buses.

Test Plan:
- Reset defaults: en[0]=1, no cfg_load -> after 3 edges clk_out[0] toggles with period 20, high 10; tick once every 20 cycles; running[0]=1.
- Odd ratio: cfg_load ch1 with div=7, high=3 while idle, then en[1]=1 -> clk_out[1] pattern 1110000 repeating; cfg_pend[1] clears before the first high.
- Mid-period reprogram: ch0 running at P=20, cfg_load div=8 high=2 at cnt=5 -> current period completes at 20 cycles, then 8-cycle periods with 2 high; no short pulse.
- Clamping: div=0 high=0 -> P=2 H=1; div=5 high=9 -> P=5 H=4.
- Graceful stop: drop en[0] at cnt=3 (high phase) -> high lasts the full 10 cycles, output low until cnt=19, then IDLE with running=0. Re-assert en during STOP -> continuous output with no gap.
- align and reset: two channels at P=10 and P=5 with offset phases; pulse align -> both show clk_out=1 and tick=1 on the same edge. Pull rst_n low mid-high -> all outputs 0 immediately (asynchronously), and the RST_DIV defaults are restored.
